// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: shares the single external data-memory port between two
// load/store lanes with round-robin fairness. Each access is sequenced through
// a request/done handshake, bounded by a timeout, and its response can be
// suppressed by a branch flush that matches the access's branch tag.
//
// Handshakes:
//   requester side - a lane holds reqN_vld and its fields stable until it sees
//   reqN_gnt; reqN_gnt is a combinational, single-cycle accept pulse raised in
//   IDLE in the same cycle as vld, and the transfer happens on that clock edge.
//   memory side - mem_req stays high with stable address/data/flags until
//   mem_in_done is seen (or the timeout expires); mem_in_done outside an access
//   is ignored.
//   response side - rsp_vld is a one-cycle pulse with no back-pressure;
//   rsp_id/rsp_data/rsp_err are meaningful only while rsp_vld is high.
module mem_req_arbiter #(
    parameter int addr_w    = 5,
    parameter int data_w    = 32,
    parameter int branch_id = 3,
    parameter int timeout   = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_vld,
    input  logic                 req0_load,
    input  logic [addr_w-1:0]    req0_addr,
    input  logic [data_w-1:0]    req0_data,
    input  logic [branch_id-1:0] req0_bid,
    output logic                 req0_gnt,
    input  logic                 req1_vld,
    input  logic                 req1_load,
    input  logic [addr_w-1:0]    req1_addr,
    input  logic [data_w-1:0]    req1_data,
    input  logic [branch_id-1:0] req1_bid,
    output logic                 req1_gnt,
    output logic                 mem_req,
    output logic                 mem_load_flag,
    output logic                 mem_store_flag,
    output logic [addr_w-1:0]    mem_addr,
    output logic [data_w-1:0]    mem_data,
    input  logic                 mem_in_done,
    input  logic [data_w-1:0]    load_data,
    input  logic                 flush_en,
    input  logic [branch_id-1:0] flush_id,
    output logic                 rsp_vld,
    output logic                 rsp_id,
    output logic [data_w-1:0]    rsp_data,
    output logic                 rsp_err,
    output logic                 busy,
    output logic [1:0]           state_dbg
);

    localparam int cnt_w = $clog2(timeout + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic                   ptr_q, ptr_d;          // 1 = favour requester 1
    logic [cnt_w-1:0]       cnt_q, cnt_d;
    logic                   kill_q, kill_d;
    logic                   hold_load_q, hold_load_d;
    logic [addr_w-1:0]      hold_addr_q, hold_addr_d;
    logic [data_w-1:0]      hold_data_q, hold_data_d;
    logic [branch_id-1:0]   hold_bid_q, hold_bid_d;
    logic                   hold_id_q, hold_id_d;
    logic [data_w-1:0]      rsp_data_q, rsp_data_d;
    logic                   rsp_err_q, rsp_err_d;

    logic elig0, elig1, pick1, held_flush;

    // State and holding registers; reset clears everything asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            ptr_q       <= 1'b0;
            cnt_q       <= '0;
            kill_q      <= 1'b0;
            hold_load_q <= 1'b0;
            hold_addr_q <= '0;
            hold_data_q <= '0;
            hold_bid_q  <= '0;
            hold_id_q   <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            kill_q      <= kill_d;
            hold_load_q <= hold_load_d;
            hold_addr_q <= hold_addr_d;
            hold_data_q <= hold_data_d;
            hold_bid_q  <= hold_bid_d;
            hold_id_q   <= hold_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Arbitration, access sequencing and response generation
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        kill_d      = kill_q;
        hold_load_d = hold_load_q;
        hold_addr_d = hold_addr_q;
        hold_data_d = hold_data_q;
        hold_bid_d  = hold_bid_q;
        hold_id_d   = hold_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        req0_gnt    = 1'b0;
        req1_gnt    = 1'b0;
        rsp_vld     = 1'b0;

        // A request whose own branch is being flushed is not worth starting
        elig0      = req0_vld && !(flush_en && (req0_bid == flush_id));
        elig1      = req1_vld && !(flush_en && (req1_bid == flush_id));
        pick1      = elig1 && (!elig0 || ptr_q);
        held_flush = flush_en && (flush_id == hold_bid_q);

        unique case (state_q)
            IDLE: begin
                // rst gating keeps the accept pulse quiet while held in reset
                if ((elig0 || elig1) && rst) begin
                    req0_gnt    = !pick1;
                    req1_gnt    = pick1;
                    hold_id_d   = pick1;
                    hold_load_d = pick1 ? req1_load : req0_load;
                    hold_addr_d = pick1 ? req1_addr : req0_addr;
                    hold_data_d = pick1 ? req1_data : req0_data;
                    hold_bid_d  = pick1 ? req1_bid  : req0_bid;
                    cnt_d       = '0;
                    kill_d      = 1'b0;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                cnt_d = cnt_q + cnt_w'(1);
                // The external access always runs to completion; only the
                // response is dropped for a flushed branch
                if (held_flush) begin
                    kill_d = 1'b1;
                end
                if (mem_in_done) begin
                    rsp_data_d = hold_load_q ? load_data : '0;
                    rsp_err_d  = 1'b0;
                    state_d    = RESP;
                end else if (cnt_q == cnt_w'(timeout)) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = RESP;
                end
            end
            RESP: begin
                rsp_vld    = !kill_q && !held_flush;
                ptr_d      = ~hold_id_q;
                kill_d     = 1'b0;
                rsp_data_d = '0;
                rsp_err_d  = 1'b0;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Memory pins and response fields are only driven in their own state
    always_comb begin
        mem_req        = (state_q == ACCESS);
        mem_load_flag  = mem_req && hold_load_q;
        mem_store_flag = mem_req && !hold_load_q;
        mem_addr       = mem_req ? hold_addr_q : '0;
        mem_data       = mem_req ? hold_data_q : '0;
        rsp_id         = (state_q == RESP) && hold_id_q;
        rsp_data       = rsp_data_q;
        rsp_err        = rsp_err_q;
        busy           = (state_q != IDLE);
        state_dbg      = state_q;
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: two requester drivers, a memory responder with a
// configurable completion delay, and a response scoreboard.
module tb_mem_req_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int BW = 3;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_vld, req0_load, req0_gnt;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_data;
    logic [BW-1:0] req0_bid;
    logic          req1_vld, req1_load, req1_gnt;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_data;
    logic [BW-1:0] req1_bid;
    logic          mem_req, mem_load_flag, mem_store_flag;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          mem_in_done;
    logic [DW-1:0] load_data;
    logic          flush_en;
    logic [BW-1:0] flush_id;
    logic          rsp_vld, rsp_id, rsp_err, busy;
    logic [DW-1:0] rsp_data;
    logic [1:0]    state_dbg;

    mem_req_arbiter #(.addr_w(AW), .data_w(DW), .branch_id(BW), .timeout(TO)) dut (
        .clk(clk), .rst(rst),
        .req0_vld(req0_vld), .req0_load(req0_load), .req0_addr(req0_addr),
        .req0_data(req0_data), .req0_bid(req0_bid), .req0_gnt(req0_gnt),
        .req1_vld(req1_vld), .req1_load(req1_load), .req1_addr(req1_addr),
        .req1_data(req1_data), .req1_bid(req1_bid), .req1_gnt(req1_gnt),
        .mem_req(mem_req), .mem_load_flag(mem_load_flag), .mem_store_flag(mem_store_flag),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_in_done(mem_in_done),
        .load_data(load_data), .flush_en(flush_en), .flush_id(flush_id),
        .rsp_vld(rsp_vld), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy), .state_dbg(state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // memory model configuration: done_lat = ACCESS cycle carrying done, 0 = never
    int            done_lat = 0;
    logic [DW-1:0] mem_val = '0;
    int            acc_cnt = 0;
    int            last_acc_len = 0;
    logic          prev_req = 1'b0;
    logic          prev_rsp = 1'b0;
    int            gnt_cyc = 0;
    int            rsp_cyc = 0;

    logic [AW-1:0] exp_addr;
    logic          exp_load;
    logic [DW-1:0] exp_data;

    // scoreboard entry: {id, err, data}
    logic [DW+1:0] exp_q[$];
    int            gnt_log[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    // memory responder + monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            acc_cnt     = 0;
            mem_in_done = 1'b0;
            prev_req    = 1'b0;
            prev_rsp    = 1'b0;
        end else begin
            if (mem_req) begin
                acc_cnt++;
                if (acc_cnt == 1) begin
                    check("mem_load_flag", mem_load_flag, exp_load);
                    check("mem_store_flag", mem_store_flag, !exp_load);
                    check("mem_data", mem_data, exp_data);
                end
                check("mem_addr", mem_addr, exp_addr);
                mem_in_done = (done_lat != 0) && (acc_cnt == done_lat);
                load_data   = mem_in_done ? mem_val : $urandom;
            end else begin
                if (prev_req) last_acc_len = acc_cnt;
                acc_cnt     = 0;
                mem_in_done = 1'b0;
                load_data   = $urandom;
            end
            prev_req = mem_req;

            if (req0_gnt) gnt_log.push_back(0);
            if (req1_gnt) gnt_log.push_back(1);
            if (req0_gnt && req1_gnt) check("gnt_both", 1, 0);

            if (prev_rsp) check("rsp_clr", {rsp_err, rsp_data}, '0);
            prev_rsp = rsp_vld;
            if (rsp_vld) begin
                rsp_cyc = cyc;
                if (exp_q.size() == 0) check("rsp_unexp", 1, 0);
                else check("rsp", {rsp_id, rsp_err, rsp_data}, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input int side, input logic v, input logic ld,
                         input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] b);
        if (side == 0) begin
            req0_vld = v; req0_load = ld; req0_addr = a; req0_data = d; req0_bid = b;
        end else begin
            req1_vld = v; req1_load = ld; req1_addr = a; req1_data = d; req1_bid = b;
        end
    endtask

    function automatic logic [DW+1:0] expect_rsp(input int side, input logic ld);
        logic err;
        err = (done_lat == 0) || (done_lat > TO + 1);
        return {side[0], err, (err || !ld) ? {DW{1'b0}} : mem_val};
    endfunction

    // Called just after a rising edge; holds the request until granted
    task automatic issue(input int side, input logic ld, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [BW-1:0] b, input bit killed);
        bit got = 0;
        drive(side, 1'b1, ld, a, d, b);
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (side == 0 ? req0_gnt : req1_gnt) got = 1;
        end
        if (!got) begin
            check("gnt_timeout", 0, 1);
        end else begin
            gnt_cyc  = cyc;
            exp_addr = a;
            exp_load = ld;
            exp_data = d;
            if (!killed) exp_q.push_back(expect_rsp(side, ld));
        end
        @(posedge clk);
        #1;
        drive(side, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) ok = 1;
        end
        if (!ok) check("idle_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic wait_mem_req();
        bit ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (mem_req) ok = 1;
        end
        if (!ok) check("mem_req_timeout", 0, 1);
    endtask

    task automatic pulse_flush(input logic [BW-1:0] id);
        wait_mem_req();
        flush_en = 1'b1;
        flush_id = id;
        @(negedge clk);
        flush_en = 1'b0;
        flush_id = '0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b0;
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0, '0);
        mem_in_done = 1'b0;
        load_data   = '0;
        flush_en    = 1'b0;
        flush_id    = '0;

        // reset: outputs quiet even with a request pending
        req0_vld = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_gnt", {req0_gnt, req1_gnt}, 0);
        check("rst_mem", {mem_req, mem_load_flag, mem_store_flag, mem_addr, mem_data}, 0);
        check("rst_rsp", {rsp_vld, rsp_id, rsp_err, rsp_data}, 0);
        check("rst_busy", {busy, state_dbg}, 0);
        req0_vld = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;

        // single load with completion on the third ACCESS cycle
        done_lat = 3; mem_val = 32'hDEADBEEF;
        issue(0, 1'b1, 5'h0A, 32'h0, 3'd0, 0);
        wait_idle();
        check("load_acc_len", last_acc_len, 3);
        check("load_latency", rsp_cyc - gnt_cyc, 4);

        // store that never completes: times out after timeout+1 cycles
        @(posedge clk); #1;
        done_lat = 0;
        issue(1, 1'b0, 5'h1F, 32'h12345678, 3'd0, 0);
        wait_idle();
        check("to_acc_len", last_acc_len, TO + 1);

        // done arriving on the timeout cycle wins
        @(posedge clk); #1;
        done_lat = TO + 1; mem_val = 32'hA5A5F00F;
        issue(0, 1'b1, 5'h13, 32'h0, 3'd1, 0);
        wait_idle();
        check("edge_acc_len", last_acc_len, TO + 1);

        // flush hitting the in-flight access: handshake completes, no response
        @(posedge clk); #1;
        done_lat = 5; mem_val = 32'h0BADF00D;
        fork
            issue(0, 1'b1, 5'h07, 32'h0, 3'd3, 1);
            pulse_flush(3'd3);
        join
        wait_idle();
        check("kill_acc_len", last_acc_len, 5);

        // unrelated flush during an access leaves the response alone
        @(posedge clk); #1;
        done_lat = 2; mem_val = 32'h600DCAFE;
        fork
            issue(1, 1'b1, 5'h04, 32'h0, 3'd4, 0);
            pulse_flush(3'd6);
        join
        wait_idle();

        // asynchronous reset in the middle of an access
        @(posedge clk); #1;
        done_lat = 0;
        fork
            issue(0, 1'b1, 5'h11, 32'h0, 3'd1, 1);
            begin
                wait_mem_req();
                repeat (3) @(posedge clk);
                #3 rst = 1'b0;
                #1;
                check("arst_drop", {mem_req, busy, rsp_vld, state_dbg}, 0);
            end
        join
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        // contention after reset: 0 first, then strict alternation
        done_lat = 1; mem_val = 32'h13572468;
        gnt_log.delete();
        fork
            begin
                issue(0, 1'b1, 5'h01, 32'h0, 3'd0, 0);
                issue(0, 1'b0, 5'h02, 32'h11112222, 3'd0, 0);
            end
            begin
                issue(1, 1'b0, 5'h03, 32'h33334444, 3'd0, 0);
                issue(1, 1'b1, 5'h04, 32'h0, 3'd0, 0);
            end
        join
        wait_idle();
        check("rr_count", gnt_log.size(), 4);
        for (int i = 0; i < 4 && i < gnt_log.size(); i++)
            check($sformatf("rr_order%0d", i), gnt_log[i], i % 2);

        // flush at grant time: pointer favours req0, but its branch is flushed
        @(posedge clk); #1;
        done_lat = 2;
        drive(0, 1'b1, 1'b1, 5'h05, 32'h0, 3'd2);
        drive(1, 1'b1, 1'b0, 5'h06, 32'hCAFEBABE, 3'd5);
        flush_en = 1'b1; flush_id = 3'd2;
        @(negedge clk);
        check("flush_gnt", {req0_gnt, req1_gnt}, 2'b01);
        exp_addr = 5'h06; exp_load = 1'b0; exp_data = 32'hCAFEBABE;
        exp_q.push_back({1'b1, 1'b0, {DW{1'b0}}});
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0, '0);
        flush_en = 1'b0; flush_id = '0;
        wait_idle();

        check("q_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
